// File: rtl/spi_config_receiver_if.sv
// SPI pin bundle plus the received-byte outputs
// of the config receiver.
interface spi_config_receiver_if;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic [7:0] data_out;
  logic       byte_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  modport slave (
    input  spi_sck, spi_mosi, spi_cs_n,
    output data_out, byte_valid, busy,
    output frame_err, overrun
  );

  modport master (
    output spi_sck, spi_mosi, spi_cs_n,
    input  data_out, byte_valid, busy,
    input  frame_err, overrun
  );
endinterface

// File: rtl/spi_config_receiver.sv
// Mode-0 MSB-first SPI byte receiver that holds each
// byte on data_out for HOLD_CYCLES, then idles.
module spi_config_receiver #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'h80
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_config_receiver_if.slave bus
);

  localparam logic [0:0] RX_IDLE  = 1'b0;
  localparam logic [0:0] RX_SHIFT = 1'b1;
  localparam logic [0:0] OUT_IDLE = 1'b0;
  localparam logic [0:0] OUT_HOLD = 1'b1;
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  logic sck_s1, sck_s2, sck_s3;
  logic cs_s1, cs_s2, cs_s3;
  logic mosi_s1, mosi_s2;
  logic sck_rise, cs_rise;

  logic [0:0] rx_state;
  logic [2:0] bit_cnt;
  logic [6:0] shift_q;
  logic       frame_err_q;
  logic       byte_done;
  logic [7:0] new_byte;

  logic [0:0] out_state;
  logic [7:0] hold_cnt;
  logic [7:0] data_q;
  logic       valid_q;
  logic       overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_s3  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sck_s1  <= bus.spi_sck;
      sck_s2  <= sck_s1;
      sck_s3  <= sck_s2;
      cs_s1   <= bus.spi_cs_n;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      mosi_s1 <= bus.spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sck_rise = sck_s2 & ~sck_s3;
  assign cs_rise  = cs_s2 & ~cs_s3;

  // CS release wins over a coincident SCK edge
  assign byte_done = (rx_state == RX_SHIFT) & ~cs_s2 &
                     sck_rise & (bit_cnt == 3'd7);
  assign new_byte  = {shift_q, mosi_s2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state    <= RX_IDLE;
      bit_cnt     <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          bit_cnt <= '0;
          if (!cs_s2) rx_state <= RX_SHIFT;
        end
        RX_SHIFT: begin
          if (cs_s2) begin
            rx_state    <= RX_IDLE;
            bit_cnt     <= '0;
            frame_err_q <= cs_rise & (bit_cnt != 3'd0);
          end else if (sck_rise) begin
            shift_q <= {shift_q[5:0], mosi_s2};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
      endcase
    end
  end

  // A fresh byte restarts the window, even on its last cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state <= OUT_IDLE;
      hold_cnt  <= '0;
      data_q    <= IDLE_BYTE;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      if (byte_done) begin
        data_q    <= new_byte;
        valid_q   <= 1'b1;
        overrun_q <= (out_state == OUT_HOLD);
        hold_cnt  <= HOLD_LOAD;
        out_state <= OUT_HOLD;
      end else if (out_state == OUT_HOLD) begin
        if (hold_cnt == 8'd0) begin
          data_q    <= IDLE_BYTE;
          out_state <= OUT_IDLE;
        end else begin
          hold_cnt <= hold_cnt - 8'd1;
        end
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.byte_valid = valid_q;
  assign bus.busy       = (out_state == OUT_HOLD);
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_spi_config_receiver.sv
// Randomised bench for spi_config_receiver: three hold
// lengths driven in parallel, checked per cycle.
module tb_spi_config_receiver;

  localparam logic [7:0] IDLE = 8'h80;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic       b;
    logic       f;
    logic       o;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck = 1'b0;
  logic mosi = 1'b0;
  logic cs_n = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spi_config_receiver_if b0 ();
  spi_config_receiver_if b1 ();
  spi_config_receiver_if b2 ();

  assign b0.spi_sck = sck;
  assign b0.spi_mosi = mosi;
  assign b0.spi_cs_n = cs_n;
  assign b1.spi_sck = sck;
  assign b1.spi_mosi = mosi;
  assign b1.spi_cs_n = cs_n;
  assign b2.spi_sck = sck;
  assign b2.spi_mosi = mosi;
  assign b2.spi_cs_n = cs_n;

  spi_config_receiver #(.HOLD_CYCLES(2)) u_h2 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  spi_config_receiver #(.HOLD_CYCLES(40)) u_h40 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  spi_config_receiver #(.HOLD_CYCLES(64)) u_h64 (
    .clk(clk), .rst_n(rst_n), .bus(b2));

  function automatic int hold_of(int d);
    case (d)
      0: return 2;
      1: return 40;
      default: return 64;
    endcase
  endfunction

  function automatic obs_t obs_now(int d);
    case (d)
      0: return {b0.data_out, b0.byte_valid, b0.busy,
                 b0.frame_err, b0.overrun};
      1: return {b1.data_out, b1.byte_valid, b1.busy,
                 b1.frame_err, b1.overrun};
      default: return {b2.data_out, b2.byte_valid, b2.busy,
                       b2.frame_err, b2.overrun};
    endcase
  endfunction

  obs_t tr [3][8192];
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) tr[d][cyc & 8191] = obs_now(d);
  end

  // Model: bytes land 3 clk after the 8th SCK rise is driven
  int         ev_cyc[$];
  logic [7:0] ev_byte[$];
  int         fe_cyc[$];
  int         fbits;
  logic [7:0] fval;

  function automatic obs_t model(int d, int c);
    obs_t e;
    int h = hold_of(d);
    int last = -1;
    int prev = -1;
    foreach (ev_cyc[i]) if (ev_cyc[i] <= c) begin
      prev = last;
      last = i;
    end
    e = {IDLE, 4'b0000};
    if (last >= 0 && c - ev_cyc[last] < h) begin
      e.d = ev_byte[last];
      e.b = 1'b1;
    end
    if (last >= 0 && ev_cyc[last] == c) begin
      e.v = 1'b1;
      e.o = (prev >= 0) && (c - ev_cyc[prev] <= h);
    end
    foreach (fe_cyc[i]) if (fe_cyc[i] == c) e.f = 1'b1;
    return e;
  endfunction

  task automatic clear_model();
    ev_cyc.delete();
    ev_byte.delete();
    fe_cyc.delete();
    fbits = 0;
    fval = '0;
  endtask

  task automatic send_bit(bit b, int hp);
    mosi = b;
    repeat (hp) @(negedge clk);
    sck = 1'b1;
    if (!cs_n) begin
      fval = {fval[6:0], b};
      fbits++;
      if (fbits == 8) begin
        ev_cyc.push_back(cyc + 3);
        ev_byte.push_back(fval);
        fbits = 0;
      end
    end
    repeat (hp) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] v, int hp);
    for (int i = 7; i >= 0; i--) send_bit(v[i], hp);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    fbits = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    if (fbits != 0) fe_cyc.push_back(cyc + 3);
    fbits = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (obs_now(d) !== {IDLE, 4'b0000}) begin
        failed++;
        $display("FAIL reset dut%0d got %h want %h",
                 d, obs_now(d), {IDLE, 4'b0000});
      end
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int c0, ce;
    clear_model();
    c0 = cyc;
    cs_low();
    send_byte(8'h25, 5);
    cs_high();
    repeat (80) @(negedge clk);
    ce = cyc;
    for (int c = c0; c < ce; c++)
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (tr[d][c & 8191] !== model(d, c)) begin
          failed++;
          $display("FAIL single dut%0d cyc%0d got %h want %h",
                   d, c, tr[d][c & 8191], model(d, c));
        end
      end
  endtask

  task automatic test_multi();
    int c0, ce;
    clear_model();
    c0 = cyc;
    cs_low();
    send_byte(8'h13, 5);
    send_byte(8'h4A, 5);
    cs_high();
    repeat (80) @(negedge clk);
    ce = cyc;
    for (int c = c0; c < ce; c++)
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (tr[d][c & 8191] !== model(d, c)) begin
          failed++;
          $display("FAIL multi dut%0d cyc%0d got %h want %h",
                   d, c, tr[d][c & 8191], model(d, c));
        end
      end
  endtask

  task automatic test_frame_err();
    int c0, ce;
    clear_model();
    c0 = cyc;
    cs_low();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 5);
    cs_high();
    cs_low();
    send_byte(8'h3A, 5);
    cs_high();
    repeat (80) @(negedge clk);
    ce = cyc;
    for (int c = c0; c < ce; c++)
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (tr[d][c & 8191] !== model(d, c)) begin
          failed++;
          $display("FAIL frame_err dut%0d cyc%0d got %h want %h",
                   d, c, tr[d][c & 8191], model(d, c));
        end
      end
  endtask

  task automatic test_back_to_back();
    int c0, ce;
    clear_model();
    c0 = cyc;
    cs_low();
    send_byte(8'h11, 4);
    send_byte(8'h22, 4);
    cs_high();
    repeat (80) @(negedge clk);
    ce = cyc;
    for (int c = c0; c < ce; c++)
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (tr[d][c & 8191] !== model(d, c)) begin
          failed++;
          $display("FAIL back_to_back dut%0d cyc%0d got %h want %h",
                   d, c, tr[d][c & 8191], model(d, c));
        end
      end
  endtask

  task automatic test_cs_high_sck();
    int c0, ce;
    clear_model();
    c0 = cyc;
    for (int i = 0; i < 16; i++) send_bit(1'($urandom), 4);
    repeat (4) @(negedge clk);
    cs_low();
    send_byte(8'hC3, 4);
    cs_high();
    repeat (80) @(negedge clk);
    ce = cyc;
    for (int c = c0; c < ce; c++)
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (tr[d][c & 8191] !== model(d, c)) begin
          failed++;
          $display("FAIL cs_high_sck dut%0d cyc%0d got %h want %h",
                   d, c, tr[d][c & 8191], model(d, c));
        end
      end
  endtask

  task automatic test_async_reset();
    int c0, ce;
    clear_model();
    c0 = cyc;
    cs_low();
    send_byte(8'hA5, 4);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 4);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    ce = cyc;
    #1;
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (obs_now(d) !== {IDLE, 4'b0000}) begin
        failed++;
        $display("FAIL async_reset dut%0d got %h want %h",
                 d, obs_now(d), {IDLE, 4'b0000});
      end
    end
    for (int c = c0; c < ce; c++)
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (tr[d][c & 8191] !== model(d, c)) begin
          failed++;
          $display("FAIL pre_reset dut%0d cyc%0d got %h want %h",
                   d, c, tr[d][c & 8191], model(d, c));
        end
      end
    cs_n = 1'b1;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    c0 = cyc;
    cs_low();
    send_byte(8'h5C, 5);
    cs_high();
    repeat (80) @(negedge clk);
    ce = cyc;
    for (int c = c0; c < ce; c++)
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (tr[d][c & 8191] !== model(d, c)) begin
          failed++;
          $display("FAIL post_reset dut%0d cyc%0d got %h want %h",
                   d, c, tr[d][c & 8191], model(d, c));
        end
      end
  endtask

  task automatic test_random();
    int c0, ce, nb, hp, nbits;
    clear_model();
    c0 = cyc;
    for (int f = 0; f < 6; f++) begin
      hp = $urandom_range(6, 4);
      nb = $urandom_range(3, 1);
      cs_low();
      for (int i = 0; i < nb; i++) send_byte(8'($urandom), hp);
      if ($urandom_range(3, 0) == 0) begin
        nbits = $urandom_range(7, 1);
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom), hp);
      end
      cs_high();
    end
    repeat (80) @(negedge clk);
    ce = cyc;
    for (int c = c0; c < ce; c++)
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (tr[d][c & 8191] !== model(d, c)) begin
          failed++;
          $display("FAIL random dut%0d cyc%0d got %h want %h",
                   d, c, tr[d][c & 8191], model(d, c));
        end
      end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_single();
    test_multi();
    test_frame_err();
    test_back_to_back();
    test_cs_high_sck();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
